// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes MIPS ALU-class instructions into the registered ID/EX operand/opcode bundle
`ifndef WORDLENGTH
`define WORDLENGTH 32
`endif
`ifndef SHAMT_LENGTH
`define SHAMT_LENGTH 5
`endif
`ifndef NO_OP
`define NO_OP    4'd0
`define ALU_ADD  4'd1
`define ALU_SUB  4'd2
`define ALU_AND  4'd3
`define ALU_OR   4'd4
`define ALU_XOR  4'd5
`define ALU_SLT  4'd6
`define ALU_SLTU 4'd7
`define ALU_SLL  4'd8
`define ALU_SRL  4'd9
`define ALU_SRA  4'd10
`endif

module alu_issue_stage #(
    parameter int WORDLENGTH   = `WORDLENGTH,
    parameter int SHAMT_LENGTH = `SHAMT_LENGTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             id_instr,
    input  logic                    id_valid,
    input  logic [WORDLENGTH-1:0]   rs_data,
    input  logic [WORDLENGTH-1:0]   rt_data,
    input  logic                    stall,
    input  logic                    flush,
    output logic [3:0]              ex_alu_op,
    output logic [WORDLENGTH-1:0]   ex_in1,
    output logic [WORDLENGTH-1:0]   ex_in2,
    output logic [SHAMT_LENGTH-1:0] ex_shamt,
    output logic [4:0]              ex_rd,
    output logic                    ex_reg_write,
    output logic                    ex_valid,
    output logic                    ex_illegal
);
    logic [5:0]              opcode, funct;
    logic [WORDLENGTH-1:0]   imm_s, imm_z;
    logic [3:0]              d_op;
    logic [WORDLENGTH-1:0]   d_in1, d_in2;
    logic [SHAMT_LENGTH-1:0] d_shamt;
    logic [4:0]              d_rd;
    logic                    d_ok, load_ok;

    assign opcode = id_instr[31:26];
    assign funct  = id_instr[5:0];
    assign imm_s  = {{(WORDLENGTH-16){id_instr[15]}}, id_instr[15:0]};
    assign imm_z  = {{(WORDLENGTH-16){1'b0}}, id_instr[15:0]};

    always_comb begin
        d_op    = `NO_OP;
        d_in1   = '0;
        d_in2   = '0;
        d_shamt = '0;
        d_rd    = '0;
        d_ok    = 1'b1;
        case (opcode)
            6'h00: begin
                d_rd  = id_instr[15:11];
                d_in1 = rs_data;
                d_in2 = rt_data;
                case (funct)
                    6'h00, 6'h02, 6'h03: begin
                        d_op    = funct == 6'h00 ? `ALU_SLL : funct == 6'h02 ? `ALU_SRL : `ALU_SRA;
                        d_in1   = rt_data;
                        d_in2   = '0;
                        d_shamt = SHAMT_LENGTH'(id_instr[10:6]);
                    end
                    6'h20, 6'h21: d_op = `ALU_ADD;
                    6'h22, 6'h23: d_op = `ALU_SUB;
                    6'h24:        d_op = `ALU_AND;
                    6'h25:        d_op = `ALU_OR;
                    6'h26:        d_op = `ALU_XOR;
                    6'h2A:        d_op = `ALU_SLT;
                    6'h2B:        d_op = `ALU_SLTU;
                    default:      d_ok = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                d_rd  = id_instr[20:16];
                d_in1 = rs_data;
                d_in2 = opcode >= 6'h0C ? imm_z : imm_s;
                d_op  = opcode <= 6'h09 ? `ALU_ADD :
                        opcode == 6'h0A ? `ALU_SLT :
                        opcode == 6'h0B ? `ALU_SLTU :
                        opcode == 6'h0C ? `ALU_AND :
                        opcode == 6'h0D ? `ALU_OR : `ALU_XOR;
            end
            6'h0F: begin
                d_rd    = id_instr[20:16];
                d_in1   = imm_z;
                d_op    = `ALU_SLL;
                d_shamt = SHAMT_LENGTH'(16);
            end
            default: d_ok = 1'b0;
        endcase
    end

    // illegal instructions still occupy the slot, but carry no operands or destination
    assign load_ok = id_valid && d_ok;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_alu_op    <= `NO_OP;
            ex_in1       <= '0;
            ex_in2       <= '0;
            ex_shamt     <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_valid     <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (!stall) begin
            ex_alu_op    <= load_ok ? d_op : `NO_OP;
            ex_in1       <= load_ok ? d_in1 : '0;
            ex_in2       <= load_ok ? d_in2 : '0;
            ex_shamt     <= load_ok ? d_shamt : '0;
            ex_rd        <= load_ok ? d_rd : '0;
            ex_reg_write <= load_ok && d_rd != 5'd0;
            ex_valid     <= id_valid;
            ex_illegal   <= id_valid && !d_ok;
        end
    end
endmodule
